// File: rtl/regfile_operand_fetch_pkg.sv
// Shared widths, FSM encoding and address-match helper for the operand fetch controller.
package regfile_operand_fetch_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 2;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_HOLD = 2'd2;

   function automatic logic addr_hit(input logic valid, input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] b);
      return valid && (a == b);
   endfunction

endpackage

// File: rtl/regfile_operand_fetch_if.sv
// Bundle of request, operand, writeback and register-file signals around the fetch controller.
interface regfile_operand_fetch_if #(
   parameter int DATA_W = regfile_operand_fetch_pkg::DATA_W,
   parameter int ADDR_W = regfile_operand_fetch_pkg::ADDR_W
);

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_rs;
   logic [ADDR_W-1:0] req_rt;

   logic              op_valid;
   logic              op_ready;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;

   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   logic              rf_write_enable;
   logic [ADDR_W-1:0] rf_write_addr;
   logic [DATA_W-1:0] rf_write_data;
   logic [ADDR_W-1:0] rf_read_addr1;
   logic [ADDR_W-1:0] rf_read_addr2;
   logic [DATA_W-1:0] rf_read_data1;
   logic [DATA_W-1:0] rf_read_data2;

   // The controller is the slave; the master side is the requester plus the register file.
   modport slave (
      input  req_valid, req_rs, req_rt, op_ready,
      input  wb_valid, wb_addr, wb_data,
      input  rf_read_data1, rf_read_data2,
      output req_ready, op_valid, op_a, op_b,
      output rf_write_enable, rf_write_addr, rf_write_data,
      output rf_read_addr1, rf_read_addr2
   );

   modport master (
      output req_valid, req_rs, req_rt, op_ready,
      output wb_valid, wb_addr, wb_data,
      output rf_read_data1, rf_read_data2,
      input  req_ready, op_valid, op_a, op_b,
      input  rf_write_enable, rf_write_addr, rf_write_data,
      input  rf_read_addr1, rf_read_addr2
   );

endinterface

// File: rtl/regfile_operand_fetch_operand_bypass_mux.sv
// Per-operand bypass: remembers a writeback seen at the accept edge and picks the freshest value at capture.
module operand_bypass_mux #(
   parameter int DATA_W = regfile_operand_fetch_pkg::DATA_W,
   parameter int ADDR_W = regfile_operand_fetch_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              accept_i,
   input  logic [ADDR_W-1:0] acc_addr_i,
   input  logic [ADDR_W-1:0] cap_addr_i,
   input  logic              wb_valid_i,
   input  logic [ADDR_W-1:0] wb_addr_i,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic [DATA_W-1:0] rf_data_i,
   output logic [DATA_W-1:0] operand_o
);

   import regfile_operand_fetch_pkg::*;

   logic              byp_flag_q, byp_flag_d;
   logic [DATA_W-1:0] byp_data_q, byp_data_d;

   // The register file reads the pre-write value when a write lands on the accept edge.
   always_comb begin
      byp_flag_d = byp_flag_q;
      byp_data_d = byp_data_q;
      if (accept_i) begin
         byp_flag_d = addr_hit(wb_valid_i, wb_addr_i, acc_addr_i);
         byp_data_d = wb_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp_flag_q <= 1'b0;
         byp_data_q <= '0;
      end else begin
         byp_flag_q <= byp_flag_d;
         byp_data_q <= byp_data_d;
      end
   end

   always_comb begin
      operand_o = rf_data_i;
      if (addr_hit(wb_valid_i, wb_addr_i, cap_addr_i)) begin
         operand_o = wb_data_i;
      end else if (byp_flag_q) begin
         operand_o = byp_data_q;
      end
   end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch controller: drives register-file reads, hides the one-cycle read latency and bypasses writebacks.
module regfile_operand_fetch #(
   parameter int DATA_W = regfile_operand_fetch_pkg::DATA_W,
   parameter int ADDR_W = regfile_operand_fetch_pkg::ADDR_W
) (
   input logic                    clk,
   input logic                    rst_n,
   regfile_operand_fetch_if.slave bus
);

   import regfile_operand_fetch_pkg::*;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d;
   logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
   logic [DATA_W-1:0] sel_a, sel_b;
   logic              pass_addr;
   logic              accept;
   logic              capture;

   assign pass_addr = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.op_ready);
   assign accept    = bus.req_valid && pass_addr;
   assign capture   = (state_q == ST_WAIT);

   assign bus.req_ready = pass_addr;
   assign bus.op_valid  = (state_q == ST_HOLD);
   assign bus.op_a      = op_a_q;
   assign bus.op_b      = op_b_q;

   assign bus.rf_write_enable = bus.wb_valid;
   assign bus.rf_write_addr   = bus.wb_addr;
   assign bus.rf_write_data   = bus.wb_data;

   // Present new addresses early whenever an accept can happen this cycle.
   assign bus.rf_read_addr1 = pass_addr ? bus.req_rs : rs_q;
   assign bus.rf_read_addr2 = pass_addr ? bus.req_rt : rt_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.req_valid) state_d = ST_WAIT;
         ST_WAIT: state_d = ST_HOLD;
         ST_HOLD: if (bus.op_ready) state_d = bus.req_valid ? ST_WAIT : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rs_d   = accept  ? bus.req_rs : rs_q;
      rt_d   = accept  ? bus.req_rt : rt_q;
      op_a_d = capture ? sel_a      : op_a_q;
      op_b_d = capture ? sel_b      : op_b_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rs_q    <= '0;
         rt_q    <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
      end else begin
         state_q <= state_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
      end
   end

   operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .accept_i   (accept),
      .acc_addr_i (bus.req_rs),
      .cap_addr_i (rs_q),
      .wb_valid_i (bus.wb_valid),
      .wb_addr_i  (bus.wb_addr),
      .wb_data_i  (bus.wb_data),
      .rf_data_i  (bus.rf_read_data1),
      .operand_o  (sel_a)
   );

   operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .accept_i   (accept),
      .acc_addr_i (bus.req_rt),
      .cap_addr_i (rt_q),
      .wb_valid_i (bus.wb_valid),
      .wb_addr_i  (bus.wb_addr),
      .wb_data_i  (bus.wb_data),
      .rf_data_i  (bus.rf_read_data2),
      .operand_o  (sel_b)
   );

endmodule
